multicycle_ctrl: RTL and testbench
==================================

# multicycle_ctrl

Multicycle sequencer for the ARM-subset CPU datapath. It walks each instruction through fetch, decode, execute, memory and writeback states. It owns the architectural NZCV flags register and gates every side effect on the condition-pass signal from the external condition evaluator. It stalls on a memory-ready handshake and drives all datapath mux selects and write enables.

## Interface
- No parameters.
- clk  in  1  system clock; all state changes on rising edge
- rst_n  in  1  synchronous active-low reset
- cond  in  4  instr[31:28]
- op  in  2  instr[27:26]: 00 data-proc, 01 LDR/STR, 10 B, 11 undefined
- funct  in  6  instr[25:20]; [0]=S (data-proc) or L (mem), [4:1]=cmd, [3]=U (mem)
- rd  in  4  instr[15:12]
- alu_flags  in  4  {N,Z,C,V} from ALU, current cycle
- cond_ex  in  1  condition pass, evaluated externally from `cond` and `flags`
- mem_ready  in  1  memory completes access this cycle
- flags  out  4  registered {N,Z,C,V}
- pc_write, ir_write, reg_write, mem_write, mem_req  out  1 each  enables/request
- adr_src  out  1  0=PC, 1=ALUOut
- alu_src_a  out  1  0=reg A, 1=PC
- alu_src_b  out  2  00=reg B, 01=extended imm, 10=const 4
- alu_control  out  2  00 ADD, 01 SUB, 10 AND, 11 ORR
- result_src  out  2  00=ALUOut, 01=read data reg, 10=ALU direct
- imm_src  out  2  equals op during DECODE onward
- reg_src  out  2  [0]=1 when op==10, [1]=1 for STR
- instr_done  out  1  one-cycle pulse on final cycle of each instruction

## Operation
- States: FETCH, DECODE, EXEC, ALUWB, MEMADR, MEMRD, MEMWB, MEMWR, BRANCH. Moore outputs, except the mem_ready qualifiers listed below.
- FETCH: mem_req=1, adr_src=0, alu_src_a=1, alu_src_b=10, alu_control=ADD, result_src=10. ir_write=pc_write=mem_ready. Advance to DECODE only when mem_ready=1; otherwise hold.
- DECODE: alu_src_a=1, alu_src_b=10, ADD (PC+8 precompute). Transitions:
  - cond_ex=0 or op==11 -> FETCH, instr_done=1, no writes.
  - op 00 -> EXEC; op 01 -> MEMADR; op 10 -> BRANCH.
- EXEC: alu_src_a=0, alu_src_b = funct[5] ? 01 : 00. cmd decode:
  - 0100 ADD, 0010 SUB, 0000 AND, 1100 ORR, 1010 CMP (SUB).
  - Any other cmd executes as ADD.
  - Next state ALUWB.
- ALUWB: result_src=00.
  - CMP: no register write.
  - rd==15: pc_write=1, reg_write=0.
  - Otherwise reg_write=1.
  - instr_done=1, then FETCH.
- Flags: written at end of EXEC when S=1 or cmd==CMP.
  - ADD/SUB/CMP load all of NZCV from alu_flags.
  - AND/ORR load NZ only; CV hold.
- MEMADR: alu_src_a=0, alu_src_b=01, alu_control = U ? ADD : SUB. Next MEMRD if L=1, else MEMWR.
- MEMRD: mem_req=1, adr_src=1. Hold until mem_ready, then MEMWB.
- MEMWB: result_src=01; reg_write=1 (or pc_write=1 if rd==15); instr_done=1; then FETCH.
- MEMWR: mem_req=1, adr_src=1, mem_write=mem_ready.
  - Hold until mem_ready, then FETCH.
  - instr_done=mem_ready.
- BRANCH: alu_src_a=1, alu_src_b=01, ADD, result_src=10, pc_write=1, instr_done=1, then FETCH.
- The flags register feeds the external evaluator. Flags change only in EXEC, so cond_ex is stable from DECODE onward.

## Timing
- Reset: state=FETCH, flags=4'b0000. While rst_n=0, all enables, mem_req and instr_done are forced to 0.
- Reset asserted mid-instruction aborts it on the next edge. No partial write occurs after the reset cycle.
- Latency with mem_ready always 1:
  - data-proc 4 cycles
  - LDR 5, STR 4
  - B 3
  - failed condition or undefined op 2
- Each cycle of mem_ready=0 in FETCH, MEMRD or MEMWR adds one cycle. mem_write and ir_write are asserted only in the mem_ready cycle, never repeated.
- Flags are visible on `flags` the cycle after EXEC.
- instr_done fires exactly once per instruction, in the cycle preceding FETCH.

## Test plan
- Reset: hold rst_n=0 for 2 cycles with mem_ready=1 -> flags=0000, state FETCH, pc_write=ir_write=0. Release -> pc_write=1 first cycle.
- ADDS (op 00, funct=001001, cond=1110), alu_flags=0110 -> 4 cycles, reg_write in cycle 4, flags=0110 after EXEC. Then ANDS with alu_flags=1000 -> flags=1010.
- CMP with alu_flags=0100, then BEQ (cond=0000, external cond_ex=1) -> pc_write in BRANCH, 3 cycles. Repeat with cond_ex=0 -> 2 cycles, no pc_write after FETCH.
- LDR (U=0) with mem_ready low for 3 cycles in MEMRD -> alu_control=SUB in MEMADR, 8 total cycles, single reg_write in MEMWB.
- STR with mem_ready delayed 2 cycles -> mem_write exactly one cycle, instr_done that same cycle, no reg_write.
- ORR with rd=15, then reset asserted in MEMADR of a following LDR -> pc_write (not reg_write) in ALUWB. After reset: FETCH, no memory request in the reset cycle, flags=0000.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multicycle sequencer for the ARM-subset CPU datapath.
// Walks each instruction through FETCH/DECODE/EXEC/ALUWB/MEMADR/MEMRD/
// MEMWB/MEMWR/BRANCH. It owns the NZCV flags register, gates side effects
// on the external condition-pass input, stalls on mem_ready, and drives the
// datapath mux selects and write enables.
//
// Ports
//   clk, rst_n        clock, synchronous active-low reset
//   cond              instr[31:28], consumed by the external evaluator only
//   op, funct, rd     instruction fields (stable while the IR holds them)
//   alu_flags         {N,Z,C,V} from the ALU in the current cycle
//   cond_ex           condition pass from the external evaluator
//   mem_ready         memory completes its access this cycle
//   flags             registered {N,Z,C,V}
//   pc_write, ir_write, reg_write, mem_write, mem_req   enables / request
//   adr_src, alu_src_a, alu_src_b, alu_control, result_src, imm_src, reg_src
//                     datapath selects
//   instr_done        one-cycle pulse on the final cycle of each instruction
//
// State table
//   state  | meaning
//   FETCH  | read instruction at PC, PC <= PC+4 when memory answers
//   DECODE | PC+8 precompute, condition/opcode dispatch
//   EXEC   | data-processing ALU operation, flag update
//   ALUWB  | write ALU result to rd (or PC when rd==15)
//   MEMADR | compute load/store address (base +/- imm)
//   MEMRD  | load access, wait for mem_ready
//   MEMWB  | write loaded data to rd (or PC)
//   MEMWR  | store access, wait for mem_ready
//   BRANCH | PC <= PC+8+offset

module multicycle_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] cond,
  input  logic [1:0] op,
  input  logic [5:0] funct,
  input  logic [3:0] rd,
  input  logic [3:0] alu_flags,
  input  logic       cond_ex,
  input  logic       mem_ready,
  output logic [3:0] flags,
  output logic       pc_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic       mem_write,
  output logic       mem_req,
  output logic       adr_src,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_control,
  output logic [1:0] result_src,
  output logic [1:0] imm_src,
  output logic [1:0] reg_src,
  output logic       instr_done
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_EXEC   = 4'd2,
    S_ALUWB  = 4'd3,
    S_MEMADR = 4'd4,
    S_MEMRD  = 4'd5,
    S_MEMWB  = 4'd6,
    S_MEMWR  = 4'd7,
    S_BRANCH = 4'd8
  } state_t;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_ORR = 4'b1100;

  state_t     state_q, state_d;
  logic [3:0] flags_q, flags_d;

  logic [3:0] cmd;
  logic       s_bit;
  logic       is_cmp;
  logic       is_logic;
  logic [1:0] exec_alu;
  logic       unused_cond;

  // cond is evaluated outside this block; kept on the port for completeness.
  assign unused_cond = ^cond;

  assign cmd      = funct[4:1];
  assign s_bit    = funct[0];
  assign is_cmp   = (cmd == CMD_CMP);
  assign is_logic = (cmd == CMD_AND) || (cmd == CMD_ORR);
  assign flags    = flags_q;

  always_comb begin
    case (cmd)
      CMD_SUB, CMD_CMP: exec_alu = ALU_SUB;
      CMD_AND:          exec_alu = ALU_AND;
      CMD_ORR:          exec_alu = ALU_ORR;
      default:          exec_alu = ALU_ADD;  // ADD and all unlisted cmds
    endcase
  end

  // State and flags registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      flags_q <= 4'b0000;
    end else begin
      state_q <= state_d;
      flags_q <= flags_d;
    end
  end

  // Next-state and next-flags logic
  always_comb begin
    state_d = state_q;
    flags_d = flags_q;
    case (state_q)
      S_FETCH:  if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        if (!cond_ex || op == 2'b11) state_d = S_FETCH;
        else if (op == 2'b00)        state_d = S_EXEC;
        else if (op == 2'b01)        state_d = S_MEMADR;
        else                         state_d = S_BRANCH;
      end
      S_EXEC: begin
        state_d = S_ALUWB;
        if (s_bit || is_cmp) begin
          // Logical ops leave carry and overflow untouched.
          if (is_logic) flags_d = {alu_flags[3:2], flags_q[1:0]};
          else          flags_d = alu_flags;
        end
      end
      S_ALUWB:  state_d = S_FETCH;
      S_MEMADR: state_d = funct[0] ? S_MEMRD : S_MEMWR;
      S_MEMRD:  if (mem_ready) state_d = S_MEMWB;
      S_MEMWB:  state_d = S_FETCH;
      S_MEMWR:  if (mem_ready) state_d = S_FETCH;
      S_BRANCH: state_d = S_FETCH;
      default:  state_d = S_FETCH;
    endcase
  end

  // Output logic
  always_comb begin
    pc_write    = 1'b0;
    ir_write    = 1'b0;
    reg_write   = 1'b0;
    mem_write   = 1'b0;
    mem_req     = 1'b0;
    instr_done  = 1'b0;
    adr_src     = 1'b0;
    alu_src_a   = 1'b0;
    alu_src_b   = 2'b00;
    alu_control = ALU_ADD;
    result_src  = 2'b00;
    imm_src     = (state_q == S_FETCH) ? 2'b00 : op;
    reg_src     = {(op == 2'b01) && !funct[0], (op == 2'b10)};
    case (state_q)
      S_FETCH: begin
        mem_req    = 1'b1;
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        ir_write   = mem_ready;
        pc_write   = mem_ready;
      end
      S_DECODE: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        if (!cond_ex || op == 2'b11) instr_done = 1'b1;
      end
      S_EXEC: begin
        alu_src_b   = funct[5] ? 2'b01 : 2'b00;
        alu_control = exec_alu;
      end
      S_ALUWB: begin
        instr_done = 1'b1;
        if (!is_cmp) begin
          if (rd == 4'd15) pc_write  = 1'b1;
          else             reg_write = 1'b1;
        end
      end
      S_MEMADR: begin
        alu_src_b   = 2'b01;
        alu_control = funct[3] ? ALU_ADD : ALU_SUB;
      end
      S_MEMRD: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
      end
      S_MEMWB: begin
        result_src = 2'b01;
        instr_done = 1'b1;
        if (rd == 4'd15) pc_write  = 1'b1;
        else             reg_write = 1'b1;
      end
      S_MEMWR: begin
        mem_req    = 1'b1;
        adr_src    = 1'b1;
        mem_write  = mem_ready;
        instr_done = mem_ready;
      end
      S_BRANCH: begin
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b01;
        result_src = 2'b10;
        pc_write   = 1'b1;
        instr_done = 1'b1;
      end
      default: ;
    endcase
    // No side effect may escape while reset is held.
    if (!rst_n) begin
      pc_write   = 1'b0;
      ir_write   = 1'b0;
      reg_write  = 1'b0;
      mem_write  = 1'b0;
      mem_req    = 1'b0;
      instr_done = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] cond;
  logic [1:0] op;
  logic [5:0] funct;
  logic [3:0] rd;
  logic [3:0] alu_flags;
  logic       cond_ex;
  logic       mem_ready;
  logic [3:0] flags;
  logic       pc_write, ir_write, reg_write, mem_write, mem_req;
  logic       adr_src, alu_src_a;
  logic [1:0] alu_src_b, alu_control, result_src, imm_src, reg_src;
  logic       instr_done;

  always #5 clk = ~clk;

  multicycle_ctrl dut (
    .clk(clk), .rst_n(rst_n), .cond(cond), .op(op), .funct(funct), .rd(rd),
    .alu_flags(alu_flags), .cond_ex(cond_ex), .mem_ready(mem_ready),
    .flags(flags), .pc_write(pc_write), .ir_write(ir_write),
    .reg_write(reg_write), .mem_write(mem_write), .mem_req(mem_req),
    .adr_src(adr_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_control(alu_control), .result_src(result_src), .imm_src(imm_src),
    .reg_src(reg_src), .instr_done(instr_done)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected per-instruction summary, produced when the instruction is issued.
  typedef struct {
    int lat;
    int n_rw;
    int n_pw;
    int n_mw;
    int n_iw;
    int n_req;
    int chk_idx;
    int alu_ctl;
    int last_wr;
    int flags;
  } exp_t;

  exp_t       sbq[$];
  logic [3:0] mflags;

  // ARM condition codes against {N,Z,C,V}
  function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cc, v;
    {n, z, cc, v} = f;
    case (c)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return cc;
      4'd3:  return !cc;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return cc && !z;
      4'd9:  return !cc || z;
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return z || (n != v);
      default: return 1'b1;
    endcase
  endfunction

  function automatic int alu_of(input logic [3:0] c);
    case (c)
      4'b0010, 4'b1010: return 1;  // SUB, CMP
      4'b0000:          return 2;  // AND
      4'b1100:          return 3;  // ORR
      default:          return 0;  // ADD
    endcase
  endfunction

  // Issue one instruction: push its expected summary, then drive its cycles.
  // fs = FETCH stall cycles, ms = memory access stall cycles.
  task automatic run_instr(input logic [1:0] op_v, input logic [5:0] fn,
                           input logic [3:0] rd_v, input logic [3:0] cond_v,
                           input logic [3:0] af, input int fs, input int ms,
                           input bit first_chk);
    exp_t       e;
    logic       pass, runs, ld;
    logic [3:0] c;
    pass = cond_pass(cond_v, mflags);
    runs = pass && (op_v != 2'b11);
    c    = fn[4:1];
    ld   = fn[0];
    e.n_iw = 1; e.n_pw = 1; e.n_rw = 0; e.n_mw = 0;
    e.n_req = fs + 1; e.chk_idx = -1; e.alu_ctl = 0; e.last_wr = 0;
    e.lat = fs + 2;
    if (runs) begin
      e.last_wr = 1;
      case (op_v)
        2'b00: begin
          e.lat = fs + 4;
          e.chk_idx = fs + 2;
          e.alu_ctl = alu_of(c);
          if (c == 4'b1010) e.last_wr = 0;
          else if (rd_v == 4'd15) e.n_pw++;
          else e.n_rw++;
          if (fn[0] || c == 4'b1010) begin
            if (c == 4'b0000 || c == 4'b1100) mflags = {af[3:2], mflags[1:0]};
            else mflags = af;
          end
        end
        2'b01: begin
          e.lat = ld ? fs + 5 + ms : fs + 4 + ms;
          e.chk_idx = fs + 2;
          e.alu_ctl = fn[3] ? 0 : 1;
          e.n_req += ms + 1;
          if (!ld) e.n_mw = 1;
          else if (rd_v == 4'd15) e.n_pw++;
          else e.n_rw++;
        end
        default: begin
          e.lat = fs + 3;
          e.n_pw++;
        end
      endcase
    end
    e.flags = int'(mflags);
    sbq.push_back(e);

    op = op_v; funct = fn; rd = rd_v; cond = cond_v;
    alu_flags = af; cond_ex = pass;
    for (int i = 0; i < e.lat; i++) begin
      mem_ready = 1'($urandom_range(0, 1));
      if (i < fs) mem_ready = 1'b0;
      else if (i == fs) mem_ready = 1'b1;
      else if (runs && op_v == 2'b01 && i >= fs + 3 && i <= fs + 3 + ms)
        mem_ready = (i == fs + 3 + ms);
      if (first_chk && i == 0) begin
        @(negedge clk);
        chk("pc_write_first_cycle", int'(pc_write), 1);
      end
      @(posedge clk); #1;
    end
  endtask

  // Monitor: accumulate activity per instruction, compare on instr_done.
  int cyc = 0, c_rw = 0, c_pw = 0, c_mw = 0, c_iw = 0, c_req = 0, got_alu = -1;

  always @(negedge clk) begin
    exp_t e;
    if (rst_n !== 1'b1) begin
      cyc = 0; c_rw = 0; c_pw = 0; c_mw = 0; c_iw = 0; c_req = 0; got_alu = -1;
    end else begin
      c_rw  += int'(reg_write);
      c_pw  += int'(pc_write);
      c_mw  += int'(mem_write);
      c_iw  += int'(ir_write);
      c_req += int'(mem_req);
      if (sbq.size() > 0 && cyc == sbq[0].chk_idx) got_alu = int'(alu_control);
      cyc++;
      if (instr_done) begin
        if (sbq.size() == 0) begin
          chk("unexpected_instr_done", sbq.size(), 1);
        end else begin
          e = sbq.pop_front();
          chk("latency", cyc, e.lat);
          chk("reg_write_count", c_rw, e.n_rw);
          chk("pc_write_count", c_pw, e.n_pw);
          chk("mem_write_count", c_mw, e.n_mw);
          chk("ir_write_count", c_iw, e.n_iw);
          chk("mem_req_cycles", c_req, e.n_req);
          chk("write_in_done_cycle", int'(reg_write | pc_write | mem_write), e.last_wr);
          chk("flags", int'(flags), e.flags);
          if (e.chk_idx >= 0) chk("alu_control", got_alu, e.alu_ctl);
        end
        cyc = 0; c_rw = 0; c_pw = 0; c_mw = 0; c_iw = 0; c_req = 0; got_alu = -1;
      end
    end
  end

  initial begin
    logic [1:0] rop;
    logic [3:0] rc;
    rst_n = 1'b0; mem_ready = 1'b1; cond = 4'hE; op = 2'b00; funct = 6'd0;
    rd = 4'd0; alu_flags = 4'd0; cond_ex = 1'b1;
    mflags = 4'b0000;

    // Reset held two cycles with mem_ready high
    @(posedge clk); @(negedge clk);
    chk("reset_flags", int'(flags), 0);
    chk("reset_pc_write", int'(pc_write), 0);
    chk("reset_ir_write", int'(ir_write), 0);
    chk("reset_mem_req", int'(mem_req), 0);
    chk("reset_instr_done", int'(instr_done), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Directed sequence
    run_instr(2'b00, 6'b001001, 4'd1, 4'hE, 4'b0110, 0, 0, 1'b1);  // ADDS
    run_instr(2'b00, 6'b000001, 4'd2, 4'hE, 4'b1000, 0, 0, 1'b0);  // ANDS
    run_instr(2'b00, 6'b010101, 4'd0, 4'hE, 4'b0100, 0, 0, 1'b0);  // CMP
    run_instr(2'b10, 6'b000000, 4'd0, 4'h0, 4'b0000, 0, 0, 1'b0);  // BEQ taken
    run_instr(2'b10, 6'b000000, 4'd0, 4'h1, 4'b0000, 0, 0, 1'b0);  // BNE not taken
    run_instr(2'b01, 6'b000001, 4'd4, 4'hE, 4'b0000, 0, 3, 1'b0);  // LDR U=0
    run_instr(2'b01, 6'b001000, 4'd5, 4'hE, 4'b0000, 0, 2, 1'b0);  // STR
    run_instr(2'b11, 6'b000000, 4'd6, 4'hE, 4'b0000, 1, 0, 1'b0);  // undefined
    run_instr(2'b00, 6'b011001, 4'd15, 4'hE, 4'b1000, 0, 0, 1'b0); // ORRS pc

    // LDR aborted by reset in MEMADR
    op = 2'b01; funct = 6'b000001; rd = 4'd3; cond = 4'hE; cond_ex = 1'b1;
    mem_ready = 1'b1;
    @(posedge clk); #1;   // FETCH
    @(posedge clk); #1;   // DECODE
    rst_n = 1'b0;         // MEMADR
    @(negedge clk);
    chk("abort_mem_req", int'(mem_req), 0);
    chk("abort_reg_write", int'(reg_write), 0);
    chk("abort_pc_write", int'(pc_write), 0);
    chk("abort_instr_done", int'(instr_done), 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("abort_flags_cleared", int'(flags), 0);
    chk("abort_fetch_no_req", int'(mem_req), 0);
    chk("abort_fetch_no_pc_write", int'(pc_write), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    mflags = 4'b0000;
    run_instr(2'b00, 6'b001001, 4'd7, 4'hE, 4'b1001, 0, 0, 1'b1);

    // Randomized instruction stream
    for (int k = 0; k < 300; k++) begin
      rop = 2'($urandom_range(0, 3));
      rc  = ($urandom_range(0, 1) != 0) ? 4'hE : 4'($urandom_range(0, 14));
      run_instr(rop, 6'($urandom_range(0, 63)),
                ($urandom_range(0, 7) == 0) ? 4'd15 : 4'($urandom_range(0, 14)),
                rc, 4'($urandom_range(0, 15)),
                $urandom_range(0, 3), $urandom_range(0, 3), 1'b0);
    end

    @(posedge clk); #1;
    chk("scoreboard_drained", sbq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
